// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: WB write, ID read/issue and hazard/status signals of reg_file_sb
interface reg_file_sb_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              RegWrite;
    logic [ADDR_W-1:0] write_reg_num;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_reg_num_1;
    logic [ADDR_W-1:0] read_reg_num_2;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_reg;
    logic              hazard_1;
    logic              hazard_2;
    logic [ADDR_W:0]   pending_count;
    logic              wb_err;
    modport master (
        output RegWrite, write_reg_num, write_data, read_reg_num_1, read_reg_num_2,
               issue_valid, issue_reg,
        input  read_data_1, read_data_2, hazard_1, hazard_2, pending_count, wb_err
    );
    modport slave (
        input  RegWrite, write_reg_num, write_data, read_reg_num_1, read_reg_num_2,
               issue_valid, issue_reg,
        output read_data_1, read_data_2, hazard_1, hazard_2, pending_count, wb_err
    );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2R/1W register file with pending-write scoreboard; REGFILE_BYPASS_EN enables WB write-through
module reg_file_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8,
    parameter int ZERO_REG = 0,
    parameter int INIT_IDX = 1
) (
    input logic          clk,
    input logic          rst,
    reg_file_sb_if.slave bus
);
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic                we;
    logic                iv;
    logic                inc;
    logic                dec;
    logic                v1;
    logic                v2;
    logic                byp1;
    logic                byp2;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (int'(a) < NUM_REGS) && !(ZERO_REG != 0 && a == '0);
    endfunction

    assign we  = bus.RegWrite && addr_ok(bus.write_reg_num);
    assign iv  = bus.issue_valid && addr_ok(bus.issue_reg);
    assign set_mask = iv ? NUM_REGS'(1) << bus.issue_reg : '0;
    assign clr_mask = we ? NUM_REGS'(1) << bus.write_reg_num : '0;
    // a same-register set+clear keeps the bit set, so it must not count as a release
    assign inc = iv && !pending[bus.issue_reg];
    assign dec = we && pending[bus.write_reg_num] && !(iv && bus.issue_reg == bus.write_reg_num);

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        // each register resets to its index (or zero) and captures WB data when addressed
        always_ff @(posedge clk or negedge rst)
            if (!rst) regs[r] <= INIT_IDX != 0 ? DATA_W'(r) : '0;
            else if (we && int'(bus.write_reg_num) == r) regs[r] <= bus.write_data;
    end

    // scoreboard bits, incremental pending count and sticky orphan-write flag
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            pending           <= '0;
            bus.pending_count <= '0;
            bus.wb_err        <= 1'b0;
        end else begin
            pending           <= (pending & ~clr_mask) | set_mask;
            bus.pending_count <= bus.pending_count + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
            bus.wb_err        <= bus.wb_err | (we && !pending[bus.write_reg_num]);
        end

    assign v1   = addr_ok(bus.read_reg_num_1);
    assign v2   = addr_ok(bus.read_reg_num_2);
    assign byp1 = BYPASS && we && bus.read_reg_num_1 == bus.write_reg_num;
    assign byp2 = BYPASS && we && bus.read_reg_num_2 == bus.write_reg_num;

    // combinational operand reads with optional write-through of the WB value
    always_comb begin
        bus.read_data_1 = byp1 ? bus.write_data : v1 ? regs[bus.read_reg_num_1] : '0;
        bus.read_data_2 = byp2 ? bus.write_data : v2 ? regs[bus.read_reg_num_2] : '0;
        bus.hazard_1    = !byp1 && v1 && pending[bus.read_reg_num_1];
        bus.hazard_2    = !byp2 && v2 && pending[bus.read_reg_num_2];
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed scoreboard bench for reg_file_sb (ZERO_REG=1, INIT_IDX=1); honours REGFILE_BYPASS_EN
module tb_reg_file_sb;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   errs = 0;
    exp_t sbq[$];

    reg_file_sb_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    reg_file_sb #(
        .DATA_W(8), .ADDR_W(3), .NUM_REGS(8), .ZERO_REG(1), .INIT_IDX(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic want(input string tag, input logic [31:0] e);
        sbq.push_back('{tag, e});
    endtask

    task automatic got(input logic [31:0] obs);
        exp_t x;
        if (sbq.size() == 0) begin
            errs++;
            $display("FAIL sb_empty: observed %0h with no expected value queued", obs);
            return;
        end
        x = sbq.pop_front();
        vectors++;
        assert (obs === x.exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", x.tag, obs, x.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.RegWrite = 0; bus.write_reg_num = 0; bus.write_data = 0;
        bus.read_reg_num_1 = 5; bus.read_reg_num_2 = 7;
        bus.issue_valid = 0; bus.issue_reg = 0;
        #12;
        want("rst_rd1", 5); want("rst_rd2", 7); want("rst_cnt", 0);
        want("rst_hz1", 0); want("rst_hz2", 0); want("rst_err", 0);
        got(bus.read_data_1); got(bus.read_data_2); got(bus.pending_count);
        got(bus.hazard_1); got(bus.hazard_2); got(bus.wb_err);
        rst = 1;
        tick();
        // issue r3 then write it back
        bus.issue_valid = 1; bus.issue_reg = 3;
        tick();
        bus.issue_valid = 0; bus.read_reg_num_1 = 3;
        #1;
        want("iss3_hz1", 1); want("iss3_cnt", 1); want("iss3_rd1", 3);
        got(bus.hazard_1); got(bus.pending_count); got(bus.read_data_1);
        bus.RegWrite = 1; bus.write_reg_num = 3; bus.write_data = 8'hA5;
        #1;
        want("wb3_same_rd1", BYP ? 8'hA5 : 8'h03); want("wb3_same_hz1", BYP ? 0 : 1);
        got(bus.read_data_1); got(bus.hazard_1);
        tick();
        bus.RegWrite = 0;
        #1;
        want("wb3_rd1", 8'hA5); want("wb3_hz1", 0); want("wb3_cnt", 0); want("wb3_err", 0);
        got(bus.read_data_1); got(bus.hazard_1); got(bus.pending_count); got(bus.wb_err);
        // r4 pending, then issue and write r4 in the same cycle
        bus.issue_valid = 1; bus.issue_reg = 4;
        tick();
        bus.RegWrite = 1; bus.write_reg_num = 4; bus.write_data = 8'h5A;
        tick();
        bus.RegWrite = 0; bus.issue_valid = 0; bus.read_reg_num_2 = 4;
        #1;
        want("same4_rd2", 8'h5A); want("same4_hz2", 1); want("same4_cnt", 1); want("same4_err", 0);
        got(bus.read_data_2); got(bus.hazard_2); got(bus.pending_count); got(bus.wb_err);
        // bypass window on r2
        bus.issue_valid = 1; bus.issue_reg = 2;
        tick();
        bus.issue_valid = 0; bus.read_reg_num_1 = 2;
        bus.RegWrite = 1; bus.write_reg_num = 2; bus.write_data = 8'h3C;
        #1;
        want("byp2_rd1", BYP ? 8'h3C : 8'h02); want("byp2_hz1", BYP ? 0 : 1); want("byp2_cnt", 2);
        got(bus.read_data_1); got(bus.hazard_1); got(bus.pending_count);
        tick();
        bus.RegWrite = 0;
        #1;
        want("wb2_rd1", 8'h3C); want("wb2_hz1", 0); want("wb2_cnt", 1);
        got(bus.read_data_1); got(bus.hazard_1); got(bus.pending_count);
        // retire r4
        bus.RegWrite = 1; bus.write_reg_num = 4; bus.write_data = 8'h77;
        tick();
        bus.RegWrite = 0;
        #1;
        want("wb4_rd2", 8'h77); want("wb4_hz2", 0); want("wb4_cnt", 0); want("wb4_err", 0);
        got(bus.read_data_2); got(bus.hazard_2); got(bus.pending_count); got(bus.wb_err);
        // r0 is hardwired: issue and write both ignored
        bus.issue_valid = 1; bus.issue_reg = 0;
        bus.RegWrite = 1; bus.write_reg_num = 0; bus.write_data = 8'hFF;
        tick();
        bus.issue_valid = 0; bus.RegWrite = 0; bus.read_reg_num_1 = 0;
        #1;
        want("r0_rd1", 0); want("r0_hz1", 0); want("r0_cnt", 0); want("r0_err", 0);
        got(bus.read_data_1); got(bus.hazard_1); got(bus.pending_count); got(bus.wb_err);
        // orphan write to r6 raises the sticky error
        bus.RegWrite = 1; bus.write_reg_num = 6; bus.write_data = 8'h66;
        tick();
        bus.RegWrite = 0; bus.read_reg_num_2 = 6;
        #1;
        want("wb6_err", 1); want("wb6_rd2", 8'h66); want("wb6_cnt", 0);
        got(bus.wb_err); got(bus.read_data_2); got(bus.pending_count);
        bus.issue_valid = 1; bus.issue_reg = 1;
        bus.RegWrite = 1; bus.write_reg_num = 1; bus.write_data = 8'h11;
        tick();
        bus.RegWrite = 0; bus.issue_reg = 2;
        tick();
        bus.issue_reg = 3;
        tick();
        bus.issue_valid = 0; bus.read_reg_num_1 = 2;
        #1;
        want("hold_err", 1); want("three_cnt", 3); want("three_hz1", 1);
        got(bus.wb_err); got(bus.pending_count); got(bus.hazard_1);
        // asynchronous reset mid-cycle with three pending registers
        rst = 0;
        #1;
        want("arst_cnt", 0); want("arst_err", 0); want("arst_hz1", 0);
        want("arst_rd1", 2); want("arst_rd2", 6);
        got(bus.pending_count); got(bus.wb_err); got(bus.hazard_1);
        got(bus.read_data_1); got(bus.read_data_2);
        rst = 1;
        tick();
        if (sbq.size() != 0) begin
            errs++;
            $display("FAIL sb_leftover: %0d expected values never compared, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
